// File: rtl/dmem_pkg.sv
// Shared definitions for the data_mem controller: default widths and FSM state encoding.
package dmem_pkg;

  localparam int DMEM_ADDR_W  = 8;
  localparam int DMEM_RDATA_W = 8;
  localparam int DMEM_WDATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO carrying a read beat and its last flag; head is always presented.
module rsp_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_last,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] data_q [2];
  logic         last_q [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         do_push;
  logic         do_pop;

  assign full      = (cnt == 2'd2);
  assign empty     = (cnt == 2'd0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = data_q[rd_ptr];
  assign head_last = last_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt       <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Request front-end for data_mem: single writes and flow-controlled burst reads
// through a two-entry response FIFO.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int RDATA_W = DMEM_RDATA_W,
  parameter int WDATA_W = DMEM_WDATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [ADDR_W-1:0]  req_len,
  input  logic [WDATA_W-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [RDATA_W-1:0] rsp_data,
  output logic               rsp_last,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_w_addr,
  output logic [WDATA_W-1:0] mem_w_data,
  output logic [ADDR_W-1:0]  mem_r_addr,
  input  logic [RDATA_W-1:0] mem_r_data
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] rd_addr_p0;
  logic [ADDR_W-1:0] len_p0;
  logic [ADDR_W-1:0] idx_p0;
  logic              vld_p1;
  logic              last_p1;
  logic              accept;
  logic              issue;
  logic              is_last_issue;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_last;
  logic [1:0]        occ;
  logic [2:0]        outstanding;

  assign req_ready     = (state == ST_IDLE) && !rst;
  assign accept        = req_valid && req_ready;
  assign mem_we        = (state == ST_WRITE);
  assign rsp_valid     = !fifo_empty;
  assign rsp_last      = rsp_valid && head_last;
  assign pop           = rsp_valid && rsp_ready;
  assign occ           = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // A beat popped on this edge frees its slot, so back-to-back issue is sustained.
  assign outstanding   = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue         = (state == ST_READ) && (outstanding < 3'd2);
  assign is_last_issue = (idx_p0 == len_p0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = req_write ? ST_WRITE : ST_READ;
      ST_WRITE: state_nxt = ST_IDLE;
      ST_READ:  if (issue && is_last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && rsp_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: request capture and address issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_w_addr <= '0;
      mem_w_data <= '0;
      mem_r_addr <= '0;
      rd_addr_p0 <= '0;
      len_p0     <= '0;
      idx_p0     <= '0;
    end else begin
      state <= state_nxt;
      if (accept && req_write) begin
        mem_w_addr <= req_addr;
        mem_w_data <= req_wdata;
      end
      if (accept && !req_write) begin
        rd_addr_p0 <= req_addr;
        len_p0     <= req_len;
        idx_p0     <= '0;
      end
      if (issue) begin
        mem_r_addr <= rd_addr_p0;
        rd_addr_p0 <= rd_addr_p0 + ADDR_W'(1);
        idx_p0     <= idx_p0 + ADDR_W'(1);
      end
    end
  end

  // Stage p1: beat in flight, data returns on mem_r_data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= issue;
      last_p1 <= issue && is_last_issue;
    end
  end

  // Stage p2: returned beat captured into the response FIFO
  rsp_fifo2 #(
    .W (RDATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data (mem_r_data),
    .push_last (last_p1),
    .pop       (pop),
    .head_data (rsp_data),
    .head_last (head_last),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
